// File: rtl/mem_release_arbiter.sv
// Release-time arbiter: each cycle picks one due, enabled FIFO head (round-robin
// or fixed priority), then registers the grant and a one-cycle pop to that FIFO.
module mem_release_arbiter #(
  parameter int NUM_CH = 4,
  parameter int TIME_W = 16,
  parameter int ADDR_W = 32,
  parameter int RAM_AW = 5,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       rr_mode,
  input  logic [NUM_CH-1:0]          ch_enable,
  input  logic [NUM_CH-1:0]          head_valid,
  input  logic [NUM_CH*TIME_W-1:0]   head_time,
  input  logic [NUM_CH*ADDR_W-1:0]   head_addr,
  input  logic [NUM_CH*RAM_AW-1:0]   head_ram_addr,
  input  logic                       out_busy,
  output logic [NUM_CH-1:0]          pop,
  output logic                       grant_valid,
  output logic [CH_W-1:0]            grant_ch,
  output logic [ADDR_W-1:0]          grant_addr,
  output logic [RAM_AW-1:0]          grant_ram_addr,
  output logic [TIME_W-1:0]          count,
  output logic                       late_flag
);

  logic [TIME_W-1:0] count_q, count_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0] pop_q, pop_d;
  logic              grant_valid_q, grant_valid_d;
  logic [CH_W-1:0]   grant_ch_q, grant_ch_d;
  logic [ADDR_W-1:0] grant_addr_q, grant_addr_d;
  logic [RAM_AW-1:0] grant_ram_addr_q, grant_ram_addr_d;
  logic              late_flag_q, late_flag_d;

  logic [TIME_W-1:0] age [NUM_CH];
  logic [NUM_CH-1:0] elig;
  logic              found;
  logic [CH_W-1:0]   sel;
  logic              issue;
  int                idx;

  // Age is modular; its MSB clear means "released within the last half range".
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      age[i]  = count_q - head_time[i*TIME_W +: TIME_W];
      elig[i] = head_valid[i] & ch_enable[i] & ~pop_q[i] & ~age[i][TIME_W-1];
    end
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (rr_mode) begin
        idx = int'(rr_ptr_q) + j;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
      end else begin
        idx = j;
      end
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = CH_W'(idx);
      end
    end
  end

  always_comb begin
    issue            = ~stall & ~out_busy & found;
    count_d          = stall ? count_q : count_q + 1'b1;
    rr_ptr_d         = rr_ptr_q;
    pop_d            = '0;
    grant_valid_d    = 1'b0;
    grant_ch_d       = grant_ch_q;
    grant_addr_d     = grant_addr_q;
    grant_ram_addr_d = grant_ram_addr_q;
    late_flag_d      = late_flag_q;
    if (issue) begin
      grant_valid_d    = 1'b1;
      pop_d            = NUM_CH'(1) << sel;
      grant_ch_d       = sel;
      grant_addr_d     = head_addr[int'(sel)*ADDR_W +: ADDR_W];
      grant_ram_addr_d = head_ram_addr[int'(sel)*RAM_AW +: RAM_AW];
      late_flag_d      = age[sel][TIME_W-2];
      rr_ptr_d         = (sel == CH_W'(NUM_CH-1)) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q          <= '0;
      rr_ptr_q         <= '0;
      pop_q            <= '0;
      grant_valid_q    <= 1'b0;
      grant_ch_q       <= '0;
      grant_addr_q     <= '0;
      grant_ram_addr_q <= '0;
      late_flag_q      <= 1'b0;
    end else begin
      count_q          <= count_d;
      rr_ptr_q         <= rr_ptr_d;
      pop_q            <= pop_d;
      grant_valid_q    <= grant_valid_d;
      grant_ch_q       <= grant_ch_d;
      grant_addr_q     <= grant_addr_d;
      grant_ram_addr_q <= grant_ram_addr_d;
      late_flag_q      <= late_flag_d;
    end
  end

  assign pop            = pop_q;
  assign grant_valid    = grant_valid_q;
  assign grant_ch       = grant_ch_q;
  assign grant_addr     = grant_addr_q;
  assign grant_ram_addr = grant_ram_addr_q;
  assign count          = count_q;
  assign late_flag      = late_flag_q;

endmodule

// File: tb/tb_mem_release_arbiter.sv
// Directed bench for mem_release_arbiter: round-robin order, pop masking,
// back-pressure, fixed priority, reset, enable mask, counter wrap and late flag.
module tb_mem_release_arbiter;
  localparam int NUM_CH = 4;
  localparam int TIME_W = 16;
  localparam int ADDR_W = 32;
  localparam int RAM_AW = 5;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     reset, stall, rr_mode, out_busy;
  logic [NUM_CH-1:0]        ch_enable, head_valid;
  logic [NUM_CH*TIME_W-1:0] head_time;
  logic [NUM_CH*ADDR_W-1:0] head_addr;
  logic [NUM_CH*RAM_AW-1:0] head_ram_addr;
  logic [NUM_CH-1:0]        pop;
  logic                     grant_valid;
  logic [CH_W-1:0]          grant_ch;
  logic [ADDR_W-1:0]        grant_addr;
  logic [RAM_AW-1:0]        grant_ram_addr;
  logic [TIME_W-1:0]        count;
  logic                     late_flag;

  logic [TIME_W-1:0] ht [NUM_CH];
  logic [TIME_W-1:0] exp_count;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      head_time[i*TIME_W +: TIME_W]     = ht[i];
      head_addr[i*ADDR_W +: ADDR_W]     = 32'h1000_0000 + 32'(i * 16);
      head_ram_addr[i*RAM_AW +: RAM_AW] = RAM_AW'(i + 1);
    end
  end

  mem_release_arbiter #(
    .NUM_CH(NUM_CH), .TIME_W(TIME_W), .ADDR_W(ADDR_W), .RAM_AW(RAM_AW)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .rr_mode(rr_mode),
    .ch_enable(ch_enable), .head_valid(head_valid), .head_time(head_time),
    .head_addr(head_addr), .head_ram_addr(head_ram_addr), .out_busy(out_busy),
    .pop(pop), .grant_valid(grant_valid), .grant_ch(grant_ch),
    .grant_addr(grant_addr), .grant_ram_addr(grant_ram_addr),
    .count(count), .late_flag(late_flag)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock edge; the counter model advances unless reset or stall is applied.
  task automatic step(input bit check_count);
    @(posedge clk);
    if (reset) exp_count = '0;
    else if (!stall) exp_count = exp_count + 1'b1;
    #1;
    if (check_count) chk("count", 64'(count), 64'(exp_count));
  endtask

  task automatic check_grant(input string tag, input bit exp_valid, input int exp_ch);
    chk({tag, ".valid"}, 64'(grant_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk({tag, ".pop"}, 64'(pop), 64'(4'b0001 << exp_ch));
      chk({tag, ".ch"}, 64'(grant_ch), 64'(exp_ch));
      chk({tag, ".addr"}, 64'(grant_addr), 64'(32'h1000_0000 + 32'(exp_ch * 16)));
      chk({tag, ".ram"}, 64'(grant_ram_addr), 64'(exp_ch + 1));
    end else begin
      chk({tag, ".pop"}, 64'(pop), 64'(0));
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; rr_mode = 1'b1; out_busy = 1'b0;
    ch_enable = 4'b1111; head_valid = 4'b0000;
    for (int i = 0; i < NUM_CH; i++) ht[i] = '0;
    exp_count = '0;

    // Reset state
    step(1'b1);
    check_grant("rst", 1'b0, 0);
    chk("rst.ch", 64'(grant_ch), 64'(0));
    chk("rst.addr", 64'(grant_addr), 64'(0));
    chk("rst.late", 64'(late_flag), 64'(0));

    // Round robin across all four channels
    reset = 1'b0; head_valid = 4'b1111;
    step(1'b1); check_grant("rr0", 1'b1, 0);
    step(1'b1); check_grant("rr1", 1'b1, 1);
    step(1'b1); check_grant("rr2", 1'b1, 2);
    step(1'b1); check_grant("rr3", 1'b1, 3);
    step(1'b1); check_grant("rr4", 1'b1, 0);

    // Single channel: pop mask forces alternate-cycle grants
    head_valid = 4'b0100;
    step(1'b1); check_grant("alt0", 1'b1, 2);
    step(1'b1); check_grant("alt1", 1'b0, 0);
    chk("alt1.hold_ch", 64'(grant_ch), 64'(2));
    step(1'b1); check_grant("alt2", 1'b1, 2);
    step(1'b1); check_grant("alt3", 1'b0, 0);

    // out_busy then stall: no issue, pointer parked on 3
    head_valid = 4'b1111; out_busy = 1'b1;
    step(1'b1); check_grant("busy0", 1'b0, 0);
    step(1'b1); check_grant("busy1", 1'b0, 0);
    step(1'b1); check_grant("busy2", 1'b0, 0);
    stall = 1'b1;
    step(1'b1); check_grant("stall0", 1'b0, 0);
    step(1'b1); check_grant("stall1", 1'b0, 0);
    stall = 1'b0; out_busy = 1'b0;
    step(1'b1); check_grant("resume", 1'b1, 3);

    // Fixed priority with channels 1 and 3
    rr_mode = 1'b0; head_valid = 4'b1010;
    step(1'b1); check_grant("fp0", 1'b1, 1);
    step(1'b1); check_grant("fp1", 1'b1, 3);
    step(1'b1); check_grant("fp2", 1'b1, 1);

    // Reset right after a grant clears pointer and outputs
    reset = 1'b1; rr_mode = 1'b1; head_valid = 4'b1111;
    step(1'b1); check_grant("mrst", 1'b0, 0);
    chk("mrst.ch", 64'(grant_ch), 64'(0));
    reset = 1'b0;
    step(1'b1); check_grant("mrst_ptr", 1'b1, 0);

    // Disabled channel is skipped
    ch_enable = 4'b1101;
    step(1'b1); check_grant("enable", 1'b1, 2);
    ch_enable = 4'b1111; head_valid = 4'b0000;

    // Counter wrap: count to 0xFFFE from a fresh reset
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    for (int n = 0; n < 16'hFFFE; n++) step(1'b0);
    chk("wrap.start", 64'(count), 64'(16'hFFFE));
    ht[1] = 16'hFFFF; ht[3] = 16'h0001; head_valid = 4'b1010;
    step(1'b1); check_grant("wrap_fffe", 1'b0, 0);
    step(1'b1); check_grant("wrap_ffff", 1'b1, 1);
    chk("wrap_ffff.late", 64'(late_flag), 64'(0));
    head_valid = 4'b1000;
    step(1'b1); check_grant("wrap_0", 1'b0, 0);
    step(1'b1); check_grant("wrap_1", 1'b1, 3);
    chk("wrap_1.late", 64'(late_flag), 64'(0));

    // Late flag: age exactly 2^(TIME_W-2) at count 2
    ht[0] = 16'hC002; head_valid = 4'b0001;
    step(1'b1); check_grant("late", 1'b1, 0);
    chk("late.flag", 64'(late_flag), 64'(1));
    head_valid = 4'b0000;
    step(1'b1);
    // Age exactly half range at count 4: not due
    ht[0] = 16'h8004; head_valid = 4'b0001;
    step(1'b1); check_grant("half", 1'b0, 0);
    chk("half.hold_late", 64'(late_flag), 64'(1));
    // Age 2^(TIME_W-2)-1 at count 5: due, not late
    ht[0] = 16'hC006;
    step(1'b1); check_grant("notlate", 1'b1, 0);
    chk("notlate.flag", 64'(late_flag), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
